md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 148 ++++++++++++++
 tb/tb_md_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit holding HI/LO with a fixed-latency busy window per operation.
// Optional build macro MD_UNIT_START_BUSY_EN also raises busy in the accept cycle of mult/div.
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [4:0] MUL_N = 5'(MUL_CYCLES);
    localparam logic [4:0] DIV_N = 5'(DIV_CYCLES);

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic signed [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic        w_wr;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_busy_int;

    assign w_prod_s = $signed(r_a) * $signed(r_b);
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // One shared unsigned divider; signed DIV runs on magnitudes and fixes signs afterwards.
    assign w_mag_a = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_mag_b = r_b[31] ? (32'd0 - r_b) : r_b;
    assign w_dvd   = r_op[0] ? r_a : w_mag_a;
    assign w_dvs   = (r_b == 32'd0) ? 32'd1 : (r_op[0] ? r_b : w_mag_b);
    assign w_q     = w_dvd / w_dvs;
    assign w_r     = w_dvd % w_dvs;

    // Result selection for the operation in flight.
    always_comb begin
        w_wr     = 1'b0;
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            3'd0: begin
                w_wr     = 1'b1;
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            3'd1: begin
                w_wr     = 1'b1;
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            3'd2: begin
                w_wr     = (r_b != 32'd0);
                w_res_lo = (r_a[31] ^ r_b[31]) ? (32'd0 - w_q) : w_q;
                w_res_hi = r_a[31] ? (32'd0 - w_r) : w_r;
            end
            3'd3: begin
                w_wr     = (r_b != 32'd0);
                w_res_lo = w_q;
                w_res_hi = w_r;
            end
            default: begin
                w_wr     = 1'b0;
                w_res_hi = r_hi;
                w_res_lo = r_lo;
            end
        endcase
    end

    // Control FSM, operand latches and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                r_state <= S_RUN;
                                r_cnt   <= op[1] ? DIV_N : MUL_N;
                                r_op    <= op;
                                r_a     <= a;
                                r_b     <= b;
                            end
                            3'd4:    r_hi <= a;
                            3'd5:    r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_cnt == 5'd1) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 5'd0;
                        if (w_wr) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 5'd0;
                end
            endcase
        end
    end

    assign w_busy_int = (r_state == S_RUN);

`ifdef MD_UNIT_START_BUSY_EN
    assign busy = w_busy_int | (start & (op <= 3'd3));
`else
    assign busy = w_busy_int;
`endif

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_md_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    md_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of an operation, straight from the instruction definitions.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sp, sq, sr;
        logic [63:0] w;
        case (o)
            3'd0: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                w = sp; m_hi = w[63:32]; m_lo = w[31:0];
            end
            3'd1: begin
                w = 64'(x) * 64'(y); m_hi = w[63:32]; m_lo = w[31:0];
            end
            3'd2: if (y != 32'd0) begin
                sq = longint'($signed(x)) / longint'($signed(y));
                sr = longint'($signed(x)) % longint'($signed(y));
                w = sq; m_lo = w[31:0];
                w = sr; m_hi = w[31:0];
            end
            3'd3: if (y != 32'd0) begin
                m_lo = x / y; m_hi = x % y;
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    // Issue one op, then watch busy and HI/LO through the whole latency window.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int intf_k, input bit rand_intf);
        int n;
        logic exp0;
        logic [31:0] old_hi, old_lo;
        n = (o <= 3'd1) ? MUL_N : ((o <= 3'd3) ? DIV_N : 0);
        old_hi = m_hi;
        old_lo = m_lo;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1;
        exp0 = 1'b0;
`ifdef MD_UNIT_START_BUSY_EN
        exp0 = (o <= 3'd3);
`endif
        check({tag, "_busy_accept"}, {31'd0, busy}, {31'd0, exp0});
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
            if (k == intf_k) begin
                start = 1'b1; op = 3'd4; a = 32'hAAAA;
            end else if (rand_intf && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
            end
            #1;
            check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            check({tag, "_hi_hold"}, hi, old_hi);
            check({tag, "_lo_hold"}, lo, old_lo);
        end
        model(o, x, y);
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
    endtask

    initial begin
        logic [2:0]  r_op_v;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 0, 1'b0);
        check("mult_hi_const", hi, 32'hFFFFFFFF);
        check("mult_lo_const", lo, 32'hFFFFFFFA);
        run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
        check("div_lo_const", lo, 32'hFFFFFFFD);
        check("div_hi_const", hi, 32'hFFFFFFFF);
        run_op("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
        check("divu_lo_const", lo, 32'h7FFFFFFC);
        check("divu_hi_const", hi, 32'd1);
        run_op("mthi", 3'd4, 32'h1234, 32'd0, 0, 1'b0);
        run_op("mtlo", 3'd5, 32'h5678, 32'd0, 0, 1'b0);
        run_op("divu0", 3'd3, 32'd5, 32'd0, 0, 1'b0);
        check("divu0_hi_const", hi, 32'h1234);
        check("divu0_lo_const", lo, 32'h5678);
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1'b0);
        check("multu_hi_const", hi, 32'hFFFFFFFE);
        check("multu_lo_const", lo, 32'd1);
        run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
        check("divovf_lo_const", lo, 32'h80000000);
        check("divovf_hi_const", hi, 32'd0);
        run_op("nop6", 3'd6, 32'hDEAD, 32'd1, 0, 1'b0);
        run_op("nop7", 3'd7, 32'hBEEF, 32'd1, 0, 1'b0);

        // Reset in the middle of a divide: result must be discarded.
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0; start = 1'b1; op = 3'd4; a = 32'hCAFE;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("first_edge_hi", hi, 32'hCAFE);
        m_hi = 32'hCAFE;
        for (int k = 0; k < DIV_N + 2; k++) begin
            @(negedge clk);
            #1;
            check("postrst_busy", {31'd0, busy}, 32'd0);
            check("postrst_lo", lo, 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            r_op_v = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", r_op_v, ra, rb, 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
